// File: rtl/cd_frame_ctrl.sv
// Frame sequencer for one cdbus CSR port: init, TX page load + start, RX page drain to a byte stream.
// CSR strobes are registered (1 cycle after decision); RX 2 cycles/byte, TX 1 byte/cycle; rx stall freezes all CSR traffic.
module cd_frame_ctrl #(
  parameter logic [4:0] ADDR_INT_FLAG = 5'h10,
  parameter logic [4:0] ADDR_INT_MASK = 5'h11,
  parameter logic [4:0] ADDR_RX       = 5'h14,
  parameter logic [4:0] ADDR_TX       = 5'h15,
  parameter logic [4:0] ADDR_RX_CTRL  = 5'h16,
  parameter logic [4:0] ADDR_TX_CTRL  = 5'h17,
  parameter logic [7:0] INT_MASK_VAL  = 8'h02
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       irq,
  output logic [4:0] csr_address,
  output logic       csr_read,
  input  logic [7:0] csr_readdata,
  output logic       csr_write,
  output logic [7:0] csr_writedata,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_last,
  input  logic       rx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ovf,
  output logic       rx_err,
  output logic [7:0] int_flag
);

  typedef enum logic [3:0] {
    S_INIT0, S_INIT1, S_IDLE,
    S_RX_FLAG, S_RX_FLAG_D, S_RX_RST, S_RX_RD, S_RX_PRES, S_RX_CLR,
    S_TX_FLAG, S_TX_FLAG_D, S_TX_RST, S_TX_BYTE, S_TX_LASTW, S_TX_START
  } state_t;

  state_t     state, state_nxt;
  logic       nxt_rd, nxt_wr;
  logic [4:0] nxt_addr;
  logic [7:0] nxt_wdata;

  logic       pres_first;
  logic [7:0] rx_hold;
  logic [1:0] hdr_cnt;
  logic [7:0] rx_rem;
  logic [8:0] tx_cnt;
  logic       ovf_seen;
  logic       rx_hs, tx_acc, rx_end;

  // First presentation cycle forwards the read data; later stall cycles replay the captured copy.
  assign rx_data  = pres_first ? csr_readdata : rx_hold;
  assign rx_valid = (state == S_RX_PRES);
  assign rx_end   = ((hdr_cnt == 2'd2) && (rx_data == 8'd0)) ||
                    ((hdr_cnt == 2'd3) && (rx_rem == 8'd1));
  assign rx_last  = rx_valid && rx_end;
  assign rx_hs    = rx_valid && rx_ready;
  assign tx_ready = (state == S_TX_BYTE);
  assign tx_acc   = tx_ready && tx_valid;
  assign tx_done  = (state == S_TX_START);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_INIT0;
      csr_read      <= 1'b0;
      csr_write     <= 1'b0;
      csr_address   <= '0;
      csr_writedata <= '0;
      int_flag      <= '0;
      rx_err        <= 1'b0;
      tx_ovf        <= 1'b0;
      pres_first    <= 1'b0;
      rx_hold       <= '0;
      hdr_cnt       <= '0;
      rx_rem        <= '0;
      tx_cnt        <= '0;
      ovf_seen      <= 1'b0;
    end else begin
      state         <= state_nxt;
      csr_read      <= nxt_rd;
      csr_write     <= nxt_wr;
      csr_address   <= nxt_addr;
      csr_writedata <= nxt_wdata;
      rx_err        <= 1'b0;
      tx_ovf        <= 1'b0;
      pres_first    <= (state == S_RX_RD);
      if (pres_first) rx_hold <= csr_readdata;

      if (state == S_RX_FLAG_D || state == S_TX_FLAG_D) begin
        int_flag <= csr_readdata;
        rx_err   <= csr_readdata[3] | csr_readdata[4];
      end

      if (state == S_RX_RST) begin
        hdr_cnt <= 2'd0;
      end else if (rx_hs) begin
        if (hdr_cnt == 2'd2) begin
          rx_rem  <= rx_data;
          hdr_cnt <= 2'd3;
        end else if (hdr_cnt == 2'd3) begin
          rx_rem  <= rx_rem - 8'd1;
        end else begin
          hdr_cnt <= hdr_cnt + 2'd1;
        end
      end

      // tx_cnt stops at 256; anything beyond is swallowed and flagged once.
      if (state == S_TX_RST) begin
        tx_cnt   <= '0;
        ovf_seen <= 1'b0;
      end else if (tx_acc) begin
        if (!tx_cnt[8]) begin
          tx_cnt <= tx_cnt + 9'd1;
        end else if (!ovf_seen) begin
          tx_ovf   <= 1'b1;
          ovf_seen <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    nxt_rd    = 1'b0;
    nxt_wr    = 1'b0;
    nxt_addr  = csr_address;
    nxt_wdata = csr_writedata;
    case (state)
      S_INIT0: begin
        nxt_wr = 1'b1; nxt_addr = ADDR_INT_MASK; nxt_wdata = INT_MASK_VAL;
        state_nxt = S_INIT1;
      end
      S_INIT1: begin
        nxt_wr = 1'b1; nxt_addr = ADDR_TX_CTRL; nxt_wdata = 8'h01;
        state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (irq) begin
          nxt_rd = 1'b1; nxt_addr = ADDR_INT_FLAG;
          state_nxt = S_RX_FLAG;
        end else if (tx_valid) begin
          nxt_rd = 1'b1; nxt_addr = ADDR_INT_FLAG;
          state_nxt = S_TX_FLAG;
        end
      end
      S_RX_FLAG: state_nxt = S_RX_FLAG_D;
      S_RX_FLAG_D: begin
        if (csr_readdata[1]) begin
          nxt_wr = 1'b1; nxt_addr = ADDR_RX_CTRL; nxt_wdata = 8'h01;
          state_nxt = S_RX_RST;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RX_RST: begin
        nxt_rd = 1'b1; nxt_addr = ADDR_RX;
        state_nxt = S_RX_RD;
      end
      S_RX_RD: state_nxt = S_RX_PRES;
      S_RX_PRES: begin
        if (rx_ready) begin
          if (rx_end) begin
            nxt_wr = 1'b1; nxt_addr = ADDR_RX_CTRL; nxt_wdata = 8'h02;
            state_nxt = S_RX_CLR;
          end else begin
            nxt_rd = 1'b1; nxt_addr = ADDR_RX;
            state_nxt = S_RX_RD;
          end
        end
      end
      S_RX_CLR: state_nxt = S_IDLE;
      S_TX_FLAG: state_nxt = S_TX_FLAG_D;
      S_TX_FLAG_D: begin
        if (csr_readdata[5]) begin
          nxt_wr = 1'b1; nxt_addr = ADDR_TX_CTRL; nxt_wdata = 8'h01;
          state_nxt = S_TX_RST;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_TX_RST: state_nxt = S_TX_BYTE;
      S_TX_BYTE: begin
        if (tx_valid) begin
          if (!tx_cnt[8]) begin
            nxt_wr = 1'b1; nxt_addr = ADDR_TX; nxt_wdata = tx_data;
          end
          if (tx_last) state_nxt = S_TX_LASTW;
        end
      end
      S_TX_LASTW: begin
        nxt_wr = 1'b1; nxt_addr = ADDR_TX_CTRL; nxt_wdata = 8'h02;
        state_nxt = S_TX_START;
      end
      S_TX_START: state_nxt = S_IDLE;
      default: state_nxt = S_INIT0;
    endcase
  end

endmodule

// File: tb/tb_cd_frame_ctrl.sv
// Scoreboard bench for cd_frame_ctrl against a behavioural cdbus CSR model.
module tb_cd_frame_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       irq;
  logic [4:0] csr_address;
  logic       csr_read, csr_write;
  logic [7:0] csr_readdata = 8'h00;
  logic [7:0] csr_writedata;
  logic       tx_valid, tx_last, tx_ready;
  logic [7:0] tx_data;
  logic       rx_valid, rx_last, rx_ready;
  logic [7:0] rx_data;
  logic       busy, tx_done, tx_ovf, rx_err;
  logic [7:0] int_flag;

  cd_frame_ctrl dut (
    .clk(clk), .reset(reset), .irq(irq),
    .csr_address(csr_address), .csr_read(csr_read), .csr_readdata(csr_readdata),
    .csr_write(csr_write), .csr_writedata(csr_writedata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last), .rx_ready(rx_ready),
    .busy(busy), .tx_done(tx_done), .tx_ovf(tx_ovf), .rx_err(rx_err), .int_flag(int_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // cdbus CSR model: INT_FLAG, auto-incrementing RX page, RX pointer reset / pending clear
  logic [7:0] flag_static = 8'h00;
  logic [7:0] rx_page [0:15];
  int         rd_ptr = 0;
  logic       rx_pend = 1'b0;
  int         arm_cnt = 0;
  int         arm_seen = 0;
  assign irq = rx_pend || (arm_cnt != arm_seen);

  always @(posedge clk) begin
    if (csr_read) begin
      case (csr_address)
        5'h10: csr_readdata <= flag_static | (irq ? 8'h02 : 8'h00);
        5'h14: begin
          csr_readdata <= rx_page[rd_ptr[3:0]];
          rd_ptr <= rd_ptr + 1;
        end
        default: csr_readdata <= 8'h00;
      endcase
    end
    if (csr_write && csr_address == 5'h16 && csr_writedata[0]) rd_ptr <= 0;
    if (csr_write && csr_address == 5'h16 && csr_writedata[1]) rx_pend <= 1'b0;
    if (arm_cnt != arm_seen) begin
      arm_seen <= arm_cnt;
      rx_pend  <= 1'b1;
    end
  end

  // Scoreboard queues and event counters
  logic [12:0] exp_wr [$];
  logic [8:0]  exp_rx [$];
  int rx_rd_cnt = 0, flag_rd_cnt = 0, tx_wr_cnt = 0;
  int done_cnt = 0, ovf_cnt = 0, err_cnt = 0;
  int wr_total = 0, init_c0 = 0, init_c1 = 0, prev_wr_cyc = 0;
  int last_flag_cyc = 0, rx_span = 0, start_gap = 0;

  always @(negedge clk) begin
    logic [12:0] got_wr;
    logic [8:0]  got_rx;
    if (!reset) begin
      if (csr_read && csr_write) check("rd_wr_exclusive", 1, 0);
      if (csr_write) begin
        got_wr = {csr_address, csr_writedata};
        if (exp_wr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL csr_wr_unexpected actual=%0h required=none", got_wr);
        end else begin
          check("csr_wr", int'(got_wr), int'(exp_wr.pop_front()));
        end
        if (csr_address == 5'h16 && csr_writedata == 8'h02) rx_span = cyc - last_flag_cyc + 1;
        if (csr_address == 5'h17 && csr_writedata == 8'h02) start_gap = cyc - prev_wr_cyc;
        if (csr_address == 5'h15) tx_wr_cnt++;
        if (wr_total == 0) init_c0 = cyc;
        if (wr_total == 1) init_c1 = cyc;
        wr_total++;
        prev_wr_cyc = cyc;
      end
      if (csr_read && csr_address == 5'h10) begin
        flag_rd_cnt++;
        last_flag_cyc = cyc;
      end
      if (csr_read && csr_address == 5'h14) rx_rd_cnt++;
      if (rx_valid && rx_ready) begin
        got_rx = {rx_last, rx_data};
        if (exp_rx.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_byte_unexpected actual=%0h required=none", got_rx);
        end else begin
          check("rx_byte", int'(got_rx), int'(exp_rx.pop_front()));
        end
      end
      if (tx_done) done_cnt++;
      if (tx_ovf)  ovf_cnt++;
      if (rx_err)  err_cnt++;
    end
  end

  logic [7:0] tx_q [$];

  task automatic send_tx();
    for (int i = 0; i < tx_q.size(); i++) begin
      int w;
      w = 0;
      tx_valid = 1'b1;
      tx_data  = tx_q[i];
      tx_last  = (i == tx_q.size() - 1);
      @(negedge clk);
      while (!tx_ready && w < 500) begin
        @(negedge clk);
        w++;
      end
      if (!tx_ready) begin
        check("tx_accept_timeout", i, -1);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int w;
    w = 0;
    @(negedge clk);
    while (!(exp_wr.size() == 0 && exp_rx.size() == 0 && !busy) && w < max) begin
      @(negedge clk);
      w++;
    end
    check("done_timeout", int'(w >= max), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic push_rx_frame(input int n);
    exp_wr.push_back({5'h16, 8'h01});
    for (int i = 0; i < n; i++) exp_rx.push_back({(i == n - 1), rx_page[i]});
    exp_wr.push_back({5'h16, 8'h02});
  endtask

  task automatic push_tx_frame();
    exp_wr.push_back({5'h17, 8'h01});
    for (int i = 0; i < tx_q.size() && i < 256; i++) exp_wr.push_back({5'h15, tx_q[i]});
    exp_wr.push_back({5'h17, 8'h02});
  endtask

  task automatic load_hdr6();
    rx_page[0] = 8'h01; rx_page[1] = 8'h02; rx_page[2] = 8'h03;
    rx_page[3] = 8'hAA; rx_page[4] = 8'hBB; rx_page[5] = 8'hCC;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_rd, b_done, b_txw, b_ovf, b_err, b_flag;
    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0; rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) rx_page[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_csr_read", csr_read, 0);
    check("rst_csr_write", csr_write, 0);
    check("rst_csr_address", csr_address, 0);
    check("rst_csr_writedata", csr_writedata, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_last", rx_last, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_int_flag", int_flag, 0);
    check("rst_pulses", {tx_done, tx_ovf, rx_err}, 0);
    check("rst_busy", busy, 1);

    // Init sequence
    exp_wr.push_back({5'h11, 8'h02});
    exp_wr.push_back({5'h17, 8'h01});
    @(posedge clk); #1 reset = 1'b0;
    wait_done(20);
    check("init_wr_gap", init_c1 - init_c0, 1);
    check("idle_busy", busy, 0);

    // Plain RX frame, no backpressure
    load_hdr6();
    push_rx_frame(6);
    b_rd = rx_rd_cnt;
    arm_cnt++;
    wait_done(100);
    check("rx_reads", rx_rd_cnt - b_rd, 6);
    check("rx_span_cycles", rx_span, 16);
    check("rx_int_flag", int_flag, 8'h02);

    // Same frame with rx_ready toggling every cycle
    push_rx_frame(6);
    b_rd = rx_rd_cnt;
    arm_cnt++;
    fork
      begin
        repeat (80) begin
          @(posedge clk);
          #1 rx_ready = ~rx_ready;
        end
      end
      wait_done(200);
    join
    rx_ready = 1'b1;
    check("rx_reads_bp", rx_rd_cnt - b_rd, 6);

    // len = 0: last flag on the len byte
    rx_page[0] = 8'h07; rx_page[1] = 8'h08; rx_page[2] = 8'h00;
    push_rx_frame(3);
    b_rd = rx_rd_cnt;
    arm_cnt++;
    wait_done(100);
    check("rx_reads_len0", rx_rd_cnt - b_rd, 3);

    // TX frame with clean buffer
    flag_static = 8'h20;
    tx_q = '{8'h05, 8'h00, 8'h02, 8'h11, 8'h22};
    push_tx_frame();
    b_done = done_cnt; b_txw = tx_wr_cnt;
    @(posedge clk); #1;
    send_tx();
    wait_done(100);
    check("tx_done_pulses", done_cnt - b_done, 1);
    check("tx_writes", tx_wr_cnt - b_txw, 5);
    check("tx_start_gap", start_gap, 1);

    // TX buffer not clean: retry loop without writes, then proceed
    flag_static = 8'h00;
    b_flag = flag_rd_cnt; b_txw = tx_wr_cnt; b_done = done_cnt;
    @(posedge clk); #1;
    fork
      send_tx();
      begin
        repeat (40) @(negedge clk);
        check("retry_flag_reads", int'((flag_rd_cnt - b_flag) > 2), 1);
        check("retry_no_tx_wr", tx_wr_cnt - b_txw, 0);
        push_tx_frame();
        flag_static = 8'h20;
      end
    join
    wait_done(100);
    check("retry_tx_done", done_cnt - b_done, 1);

    // irq and tx_valid in the same IDLE cycle: RX first
    load_hdr6();
    push_rx_frame(6);
    tx_q = '{8'h31, 8'h32, 8'h00};
    push_tx_frame();
    @(posedge clk); #1;
    arm_cnt++;
    send_tx();
    wait_done(200);

    // irq raised mid-TX: TX completes first
    tx_q = '{8'h41, 8'h42, 8'h03, 8'h44, 8'h45, 8'h46};
    push_tx_frame();
    push_rx_frame(6);
    @(posedge clk); #1;
    fork
      send_tx();
      begin
        int w;
        w = 0;
        while (!tx_ready && w < 100) begin
          @(negedge clk);
          w++;
        end
        check("mid_tx_ready_seen", int'(tx_ready), 1);
        @(posedge clk); #1;
        arm_cnt++;
      end
    join
    wait_done(200);

    // 260-byte frame: 256 writes, single overflow pulse, start still issued
    tx_q = {};
    for (int i = 0; i < 260; i++) tx_q.push_back(8'(i));
    push_tx_frame();
    b_done = done_cnt; b_txw = tx_wr_cnt; b_ovf = ovf_cnt;
    @(posedge clk); #1;
    send_tx();
    wait_done(400);
    check("ovf_tx_writes", tx_wr_cnt - b_txw, 256);
    check("ovf_pulses", ovf_cnt - b_ovf, 1);
    check("ovf_tx_done", done_cnt - b_done, 1);

    // INT_FLAG = 12: error pulse, frame still drained
    flag_static = 8'h10;
    rx_page[0] = 8'h07; rx_page[1] = 8'h08; rx_page[2] = 8'h00;
    push_rx_frame(3);
    b_err = err_cnt;
    arm_cnt++;
    wait_done(100);
    check("rx_err_pulses", err_cnt - b_err, 1);
    check("err_int_flag", int_flag, 8'h12);

    check("exp_wr_drained", exp_wr.size(), 0);
    check("exp_rx_drained", exp_rx.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
